// File: rtl/sbox_serial_seq.sv
// Sequencer for a bit-serial S-box shift register: counts bits/bytes of one block,
// strobes the S-box parallel load and flags which serial output bits are substituted.
//
// state | meaning
// IDLE  | waiting for start, counters and sub_seen cleared
// LOAD  | accepting serial input bits, loading each completed byte through the S-box
// FLUSH | 8 forced shifts to emit the last substituted byte
// DONE  | one-cycle end-of-block pulse
module sbox_serial_seq #(
  parameter int NBYTES = 16,
  parameter int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          ctrl_sbox,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic [2:0]    bit_idx,
  output logic [BW-1:0] byte_idx
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  state_t state;
  logic   flushing;
  logic   last_bit;   // LOAD with bit_idx==7: next accepted bit completes a byte
  logic   sub_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      flushing <= 1'b0;
      last_bit <= 1'b0;
      sub_seen <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_idx  <= 3'd0;
          byte_idx <= '0;
          sub_seen <= 1'b0;
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (in_valid) begin
            bit_idx  <= bit_idx + 3'd1;
            last_bit <= (bit_idx == 3'd6);
            if (bit_idx == 3'd7) begin
              sub_seen <= 1'b1;
              if (byte_idx == LAST_BYTE) begin
                state    <= FLUSH;
                in_ready <= 1'b0;
                flushing <= 1'b1;
              end else begin
                byte_idx <= byte_idx + BW'(1);
              end
            end
          end
        end
        FLUSH: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state    <= DONE;
            flushing <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          busy     <= 1'b0;
          sub_seen <= 1'b0;
          bit_idx  <= 3'd0;
          byte_idx <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_valid only gates registered qualifiers; no deeper input-to-output path.
  assign shift_en  = (in_ready & in_valid) | flushing;
  assign ctrl_sbox = last_bit & in_valid;
  assign out_valid = (in_ready & in_valid & sub_seen) | flushing;

endmodule

// File: tb/tb_sbox_serial_seq.sv
// Bench for sbox_serial_seq: a shift-register model scores the serial output bytes,
// and event cycles are compared against the nominal/stalled block timing.
module tb_sbox_serial_seq;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_bit;

  logic       in_ready2, shift_en2, ctrl2, out_valid2, busy2, done2;
  logic [2:0] bit_idx2;
  logic [0:0] byte_idx2;
  logic       in_ready1, shift_en1, ctrl1, out_valid1, busy1, done1;
  logic [2:0] bit_idx1;
  logic [0:0] byte_idx1;

  sbox_serial_seq #(.NBYTES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready2), .shift_en(shift_en2), .ctrl_sbox(ctrl2), .out_valid(out_valid2),
    .busy(busy2), .done(done2), .bit_idx(bit_idx2), .byte_idx(byte_idx2)
  );

  sbox_serial_seq #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready1), .shift_en(shift_en1), .ctrl_sbox(ctrl1), .out_valid(out_valid1),
    .busy(busy1), .done(done1), .bit_idx(bit_idx1), .byte_idx(byte_idx1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return {x[4:0], x[7:5]} ^ 8'h63;
  endfunction

  // Shift register driven by dut2's controls
  logic [7:0] sr = 8'h00;
  always @(posedge clk)
    if (shift_en2) sr <= ctrl2 ? sbox_f({sr[6:0], in_bit}) : {sr[6:0], in_bit};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int ptr;
  logic [7:0] bytes [8];
  logic exp_q [$];
  int ctrl_q [$], done_q [$], ctrl1_q [$], done1_q [$];
  int ov_cnt, ov_first, ov_last, ov1_cnt, ov1_first, ov1_last, b1_nz, n_early;
  int eq [$];

  task automatic chk(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag, input int got [$], input int expv [$]);
    chk({tag, "_count"}, got.size(), expv.size());
    for (int i = 0; i < got.size() && i < expv.size(); i++)
      chk({tag, "_cycle"}, got[i], expv[i]);
  endtask

  task automatic clr_stats();
    ctrl_q.delete(); done_q.delete(); ctrl1_q.delete(); done1_q.delete();
    ov_cnt = 0; ov_first = -1; ov_last = -1;
    ov1_cnt = 0; ov1_first = -1; ov1_last = -1;
    b1_nz = 0; n_early = 0;
  endtask

  task automatic observe();
    if (ctrl2) ctrl_q.push_back(cyc);
    if (done2) done_q.push_back(cyc);
    if (out_valid2) begin
      ov_cnt++;
      if (ov_first < 0) ov_first = cyc;
      ov_last = cyc;
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sb_bit", int'(sr[7]), int'(exp_q.pop_front()));
    end
    if (in_ready2 && !in_valid) begin
      chk("stall_shift_en", int'(shift_en2), 0);
      chk("stall_out_valid", int'(out_valid2), 0);
      chk("stall_ctrl_sbox", int'(ctrl2), 0);
    end
    if (ctrl1) ctrl1_q.push_back(cyc);
    if (done1) done1_q.push_back(cyc);
    if (out_valid1) begin
      ov1_cnt++;
      if (ov1_first < 0) ov1_first = cyc;
      ov1_last = cyc;
    end
    if (byte_idx1 != 1'b0) b1_nz++;
  endtask

  // Drive one cycle's inputs just after the edge, sample outputs at the falling edge.
  task automatic tick(input logic v, input logic st, input logic rs);
    logic [7:0] sb;
    @(posedge clk);
    #2;
    cyc++;
    in_valid = v; start = st; rst = rs;
    if (v && in_ready2 && ptr < 64) begin
      in_bit = bytes[ptr / 8][7 - (ptr % 8)];
      ptr++;
      if (ptr % 8 == 0) begin
        sb = sbox_f(bytes[(ptr / 8) - 1]);
        for (int k = 7; k >= 0; k--) exp_q.push_back(sb[k]);
      end
    end else begin
      in_bit = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    observe();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dut2"}, int'({busy2, done2, in_ready2, shift_en2, ctrl2, out_valid2,
                              bit_idx2, byte_idx2}), 0);
    chk({tag, "_dut1"}, int'({busy1, done1, in_ready1, shift_en1, ctrl1, out_valid1,
                              bit_idx1, byte_idx1}), 0);
  endtask

  task automatic check_nominal(input int c);
    int eb, eby;
    if (c >= 1 && c <= 16) begin eb = (c - 1) % 8; eby = (c - 1) / 8; end
    else if (c >= 17 && c <= 24) begin eb = c - 17; eby = 1; end
    else if (c == 25) begin eb = 0; eby = 1; end
    else begin eb = 0; eby = 0; end
    chk("nom_busy", int'(busy2), int'(c >= 1 && c <= 25));
    chk("nom_in_ready", int'(in_ready2), int'(c >= 1 && c <= 16));
    chk("nom_shift_en", int'(shift_en2), int'(c >= 1 && c <= 24));
    chk("nom_done", int'(done2), int'(c == 25));
    chk("nom_bit_idx", int'(bit_idx2), eb);
    chk("nom_byte_idx", int'(byte_idx2), eby);
  endtask

  task automatic run(input int mode, input int ncyc);
    logic v, st, rs;
    clr_stats();
    for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom_range(0, 255));
    ptr = 0;
    cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      v = 1'b1; st = (c == 0); rs = 1'b0;
      case (mode)
        2: v  = !(c == 3 || c == 4 || c == 12);
        3: st = (c == 0 || c == 5 || c == 20);
        4: rs = (c == 5);
        5: begin st = (c < 52); rs = (c == 52); end
        default: ;
      endcase
      tick(v, st, rs);
      if (mode == 1) check_nominal(c);
      if (mode == 4 && c == 6) check_idle("rst_mid_idle");
      if (mode == 5 && c >= 26 && c <= 34 && out_valid2) n_early++;
      if (mode == 5 && c == 27) begin
        chk("blk2_in_ready", int'(in_ready2), 1);
        chk("blk2_counters", int'({bit_idx2, byte_idx2}), 0);
      end
    end
    chk("sb_leftover", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cyc = -1; ptr = 0;
    clr_stats();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check_idle("reset");
    tick(1'b0, 1'b0, 1'b0);

    // Nominal block, in_valid always high; the NBYTES=1 instance runs alongside
    run(1, 30);
    eq = {8, 16};  chk_q("t1_ctrl", ctrl_q, eq);
    eq = {25};     chk_q("t1_done", done_q, eq);
    chk("t1_ov_count", ov_cnt, 16);
    chk("t1_ov_first", ov_first, 9);
    chk("t1_ov_last", ov_last, 24);
    eq = {8};      chk_q("n1_ctrl", ctrl1_q, eq);
    eq = {17};     chk_q("n1_done", done1_q, eq);
    chk("n1_ov_count", ov1_cnt, 8);
    chk("n1_ov_first", ov1_first, 9);
    chk("n1_ov_last", ov1_last, 16);
    chk("n1_byte_idx_nonzero", b1_nz, 0);

    // Stalls in cycles 3, 4 and 12
    run(2, 31);
    eq = {10, 19}; chk_q("t2_ctrl", ctrl_q, eq);
    eq = {28};     chk_q("t2_done", done_q, eq);
    chk("t2_ov_count", ov_cnt, 16);
    chk("t2_ov_first", ov_first, 11);
    chk("t2_ov_last", ov_last, 27);

    // start re-asserted in LOAD and FLUSH is ignored
    run(3, 32);
    eq = {8, 16};  chk_q("t3_ctrl", ctrl_q, eq);
    eq = {25};     chk_q("t3_done", done_q, eq);
    chk("t3_ov_count", ov_cnt, 16);

    // Reset mid byte 0, then a fresh block with nominal timing
    run(4, 8);
    chk("t4_ctrl_before_rst", ctrl_q.size(), 0);
    run(1, 30);
    eq = {8, 16};  chk_q("t4_ctrl", ctrl_q, eq);
    eq = {25};     chk_q("t4_done", done_q, eq);
    chk("t4_ov_count", ov_cnt, 16);

    // start held high: two back-to-back blocks
    run(5, 53);
    eq = {8, 16, 34, 42}; chk_q("t6_ctrl", ctrl_q, eq);
    eq = {25, 51};        chk_q("t6_done", done_q, eq);
    chk("t6_ov_count", ov_cnt, 32);
    chk("t6_ov_before_load", n_early, 0);
    tick(1'b0, 1'b0, 1'b0);
    check_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
